// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and response encodings used by the read-path arbiter.
package axi4_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi4_ar_arbiter_if.sv
// Bundle of upstream (s_*) and downstream (m_*) AR/R signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric.
interface axi4_ar_arbiter_if
  import axi4_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned MID_W = ID_W + IDX_W;

  // upstream AR
  logic [NUM_MASTERS-1:0]        s_arvalid;
  logic [NUM_MASTERS-1:0]        s_arready;
  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr;
  logic [NUM_MASTERS*ID_W-1:0]   s_arid;
  logic [NUM_MASTERS*LEN_W-1:0]  s_arlen;
  // upstream R
  logic [NUM_MASTERS-1:0]        s_rvalid;
  logic [NUM_MASTERS-1:0]        s_rready;
  logic [DATA_W-1:0]             s_rdata;
  logic [ID_W-1:0]               s_rid;
  logic [RESP_W-1:0]             s_rresp;
  logic                          s_rlast;
  // downstream AR
  logic                          m_arvalid;
  logic                          m_arready;
  logic [ADDR_W-1:0]             m_araddr;
  logic [MID_W-1:0]              m_arid;
  logic [LEN_W-1:0]              m_arlen;
  // downstream R
  logic                          m_rvalid;
  logic                          m_rready;
  logic [DATA_W-1:0]             m_rdata;
  logic [MID_W-1:0]              m_rid;
  logic [RESP_W-1:0]             m_rresp;
  logic                          m_rlast;

  modport slave (
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_rready,
           m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
    output s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
           m_arvalid, m_araddr, m_arid, m_arlen, m_rready
  );

  modport master (
    output s_arvalid, s_araddr, s_arid, s_arlen, s_rready,
           m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
    input  s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
           m_arvalid, m_araddr, m_arid, m_arlen, m_rready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: lowest requester at or above ptr wins, else lowest overall.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Mask off requesters below ptr, fall back to the full set on wrap, isolate lowest bit
  always_comb begin
    mask  = ~((N'(1) << ptr) - N'(1));
    hi    = req & mask;
    pick  = (|hi) ? hi : req;
    grant = pick & (~pick + N'(1));
    valid = |req;
  end

endmodule

// File: rtl/axi4_ar_arbiter.sv
// N:1 AXI4 read-address arbiter with ID-prefix R routing and per-master outstanding limit.
module axi4_ar_arbiter
  import axi4_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_OUTST   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  axi4_ar_arbiter_if.slave        bus,
  output logic                    err_badid
);

  localparam int unsigned IDX_W    = $clog2(NUM_MASTERS);
  localparam int unsigned MID_W    = ID_W + IDX_W;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1);
  localparam int unsigned IDX_SPAN = 1 << IDX_W;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic                   grant_valid;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       gidx;
  logic                   slot_load;
  logic                   ar_fire;
  logic [ADDR_W-1:0]      sel_addr;
  logic [ID_W-1:0]        sel_id;
  logic [LEN_W-1:0]       sel_len;

  logic [IDX_W-1:0]       ridx;
  logic [IDX_SPAN-1:0]    idx_ok;
  logic                   rbad;
  logic                   r_sel_ready;
  logic                   rlast_fire;

  logic [CNT_W-1:0]       cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] cnt_inc;
  logic [NUM_MASTERS-1:0] cnt_dec;

  // Masters at their outstanding limit drop out of arbitration
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = bus.s_arvalid[i] && (cnt[i] != CNT_W'(MAX_OUTST));
    end
  end

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  // Encode the one-hot grant and mux the winner's AR payload
  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    sel_id   = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        gidx     = IDX_W'(i);
        sel_addr = bus.s_araddr[i*ADDR_W +: ADDR_W];
        sel_id   = bus.s_arid[i*ID_W +: ID_W];
        sel_len  = bus.s_arlen[i*LEN_W +: LEN_W];
      end
    end
  end

  assign slot_load     = !bus.m_arvalid || bus.m_arready;
  assign ar_fire       = grant_valid && slot_load && !rst;
  assign bus.s_arready = ar_fire ? grant : '0;

  // Single registered AR slot; payload held until the downstream accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_arvalid <= 1'b0;
      bus.m_araddr  <= '0;
      bus.m_arid    <= '0;
      bus.m_arlen   <= '0;
    end else if (slot_load) begin
      bus.m_arvalid <= ar_fire;
      if (ar_fire) begin
        bus.m_araddr <= sel_addr;
        bus.m_arid   <= {gidx, sel_id};
        bus.m_arlen  <= sel_len;
      end
    end
  end

  // Round-robin pointer advances past the winner only on an actual grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (ar_fire) begin
      ptr <= (gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + IDX_W'(1);
    end
  end

  // Index values that name a real master (non-power-of-two counts leave holes)
  always_comb begin
    idx_ok = '0;
    for (int i = 0; i < IDX_SPAN; i++) begin
      idx_ok[i] = ($unsigned(i) < NUM_MASTERS);
    end
  end

  assign ridx = bus.m_rid[MID_W-1:ID_W];
  assign rbad = !idx_ok[ridx];

  // Combinational R steering by ID prefix; unknown prefixes are sunk
  always_comb begin
    bus.s_rvalid = '0;
    r_sel_ready  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ridx == IDX_W'(i)) begin
        bus.s_rvalid[i] = bus.m_rvalid;
        r_sel_ready     = bus.s_rready[i];
      end
    end
    bus.m_rready = rbad || r_sel_ready;
  end

  assign bus.s_rdata = bus.m_rdata;
  assign bus.s_rid   = bus.m_rid[ID_W-1:0];
  assign bus.s_rresp = bus.m_rresp;
  assign bus.s_rlast = bus.m_rlast;

  assign rlast_fire = bus.m_rvalid && bus.m_rready && bus.m_rlast && !rbad;

  // Counter events; a decrement at zero can only come from stray traffic and is dropped
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cnt_inc[i] = ar_fire && grant[i];
      cnt_dec[i] = rlast_fire && (ridx == IDX_W'(i)) && (cnt[i] != '0);
    end
  end

  // Per-master outstanding burst counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky flag for R beats carrying a prefix with no master behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_badid <= 1'b0;
    end else if (bus.m_rvalid && rbad) begin
      err_badid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_ar_arbiter.sv
// Directed bench: 4-master instance (limit 2) and 3-master instance (limit 4).
module tb_axi4_ar_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_a;
  logic err_b;

  int ntotal = 0;
  int npass  = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  axi4_ar_arbiter_if #(.NUM_MASTERS(4), .ID_W(4), .ADDR_W(32), .DATA_W(32)) ia ();
  axi4_ar_arbiter_if #(.NUM_MASTERS(3), .ID_W(4), .ADDR_W(32), .DATA_W(32)) ib ();

  axi4_ar_arbiter #(
    .NUM_MASTERS(4), .ID_W(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (ia.slave),
    .err_badid (err_a)
  );

  axi4_ar_arbiter #(
    .NUM_MASTERS(3), .ID_W(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (ib.slave),
    .err_badid (err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ia.s_arvalid = 4'hF;
    ia.s_araddr  = {32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
    ia.s_arid    = 16'h9765;
    ia.s_arlen   = {8'd15, 8'd7, 8'd0, 8'd3};
    ia.s_rready  = '0;
    ia.m_arready = 1'b1;
    ia.m_rvalid  = 1'b0;
    ia.m_rdata   = '0;
    ia.m_rid     = '0;
    ia.m_rresp   = '0;
    ia.m_rlast   = 1'b0;

    ib.s_arvalid = '0;
    ib.s_araddr  = {32'h2000_0200, 32'h2000_0100, 32'h2000_0000};
    ib.s_arid    = 12'h0B0;
    ib.s_arlen   = '0;
    ib.s_rready  = '0;
    ib.m_arready = 1'b1;
    ib.m_rvalid  = 1'b0;
    ib.m_rdata   = '0;
    ib.m_rid     = '0;
    ib.m_rresp   = '0;
    ib.m_rlast   = 1'b0;

    // reset held with every master requesting
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk("rst_arvalid", 64'(ia.m_arvalid), 64'd0);
      chk("rst_arready", 64'(ia.s_arready), 64'd0);
      chk("rst_badid",   64'(err_a),        64'd0);
    end

    // fairness: grants 0,1,2,3,0
    tick(); rst = 1'b0; settle();
    chk("rr_c0_ready", 64'(ia.s_arready), 64'h1);
    chk("rr_c0_valid", 64'(ia.m_arvalid), 64'd0);
    tick(); settle();
    chk("rr_c1_valid", 64'(ia.m_arvalid), 64'd1);
    chk("rr_c1_id",    64'(ia.m_arid),    64'h05);
    chk("rr_c1_addr",  64'(ia.m_araddr),  64'h1000_0000);
    chk("rr_c1_ready", 64'(ia.s_arready), 64'h2);
    tick(); settle();
    chk("rr_c2_id",    64'(ia.m_arid),    64'h16);
    chk("rr_c2_ready", 64'(ia.s_arready), 64'h4);
    tick(); settle();
    chk("rr_c3_id",    64'(ia.m_arid),    64'h27);
    chk("rr_c3_len",   64'(ia.m_arlen),   64'd7);
    chk("rr_c3_ready", 64'(ia.s_arready), 64'h8);
    tick(); settle();
    chk("rr_c4_id",    64'(ia.m_arid),    64'h39);
    chk("rr_c4_ready", 64'(ia.s_arready), 64'h1);

    // backpressure: five stalled cycles
    tick(); ia.m_arready = 1'b0; settle();
    chk("bp_id0",    64'(ia.m_arid),    64'h05);
    chk("bp_ready0", 64'(ia.s_arready), 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      chk("bp_valid", 64'(ia.m_arvalid), 64'd1);
      chk("bp_addr",  64'(ia.m_araddr),  64'h1000_0000);
      chk("bp_id",    64'(ia.m_arid),    64'h05);
      chk("bp_ready", 64'(ia.s_arready), 64'h0);
    end
    tick(); ia.m_arready = 1'b1; settle();
    chk("bp_release", 64'(ia.s_arready), 64'h2);
    tick(); settle();
    chk("post_bp_id",    64'(ia.m_arid),    64'h16);
    chk("post_bp_ready", 64'(ia.s_arready), 64'h4);
    tick(); settle();
    chk("post_bp_ready3", 64'(ia.s_arready), 64'h8);
    tick(); settle();
    chk("all_full_ready", 64'(ia.s_arready), 64'h0);
    chk("all_full_id",    64'(ia.m_arid),    64'h39);

    // outstanding limit on master 1 and release by rlast
    tick(); ia.s_arvalid = 4'b0010; settle();
    chk("lim_masked", 64'(ia.s_arready), 64'h0);
    chk("lim_idle",   64'(ia.m_arvalid), 64'd0);
    tick();
    ia.m_rvalid = 1'b1; ia.m_rid = 6'h16; ia.m_rlast = 1'b1; ia.s_rready = 4'b0010;
    settle();
    chk("lim_rvalid",   64'(ia.s_rvalid),  64'h2);
    chk("lim_rready",   64'(ia.m_rready),  64'd1);
    chk("lim_rid",      64'(ia.s_rid),     64'h6);
    chk("lim_still",    64'(ia.s_arready), 64'h0);
    tick();
    ia.m_rvalid = 1'b0; ia.m_rlast = 1'b0; ia.s_rready = '0;
    settle();
    chk("lim_regrant", 64'(ia.s_arready), 64'h2);
    tick(); ia.s_arvalid = '0; settle();
    chk("lim_valid", 64'(ia.m_arvalid), 64'd1);
    chk("lim_id",    64'(ia.m_arid),    64'h16);

    // asynchronous reset mid-cycle with an AR in the slot
    #2; rst = 1'b1; ia.s_arvalid = 4'hF; #1;
    chk("arst_valid", 64'(ia.m_arvalid), 64'd0);
    chk("arst_ready", 64'(ia.s_arready), 64'h0);
    tick(); rst = 1'b0; settle();
    chk("arst_cleared", 64'(ia.s_arready), 64'h1);
    tick(); ia.s_arvalid = '0; settle();
    chk("arst_id", 64'(ia.m_arid), 64'h05);

    // R routing to master 2
    tick();
    ia.m_rvalid = 1'b1; ia.m_rid = 6'h2A; ia.m_rlast = 1'b0;
    ia.m_rdata = 32'hDEAD_BEEF; ia.m_rresp = 2'b10; ia.s_rready = '0;
    settle();
    chk("rt_rvalid", 64'(ia.s_rvalid), 64'h4);
    chk("rt_rid",    64'(ia.s_rid),    64'hA);
    chk("rt_rready0", 64'(ia.m_rready), 64'd0);
    chk("rt_rdata",  64'(ia.s_rdata),  64'hDEAD_BEEF);
    chk("rt_rresp",  64'(ia.s_rresp),  64'h2);
    ia.s_rready = 4'b0100; settle();
    chk("rt_rready1", 64'(ia.m_rready), 64'd1);
    tick(); ia.m_rvalid = 1'b0; ia.s_rready = '0;

    // 3-master instance: bad prefix is sunk and flagged
    tick();
    ib.m_rvalid = 1'b1; ib.m_rid = 6'h31; ib.m_rlast = 1'b1;
    settle();
    chk("bad_rready", 64'(ib.m_rready), 64'd1);
    chk("bad_rvalid", 64'(ib.s_rvalid), 64'h0);
    chk("bad_pre",    64'(err_b),       64'd0);
    tick(); ib.m_rvalid = 1'b0; ib.m_rlast = 1'b0; settle();
    chk("bad_flag", 64'(err_b), 64'd1);
    tick(); settle();
    chk("bad_sticky", 64'(err_b), 64'd1);

    // rlast to master 1 while its count is zero is ignored
    tick();
    ib.m_rvalid = 1'b1; ib.m_rid = 6'h10; ib.m_rlast = 1'b1; ib.s_rready = 3'b010;
    settle();
    chk("z_rvalid", 64'(ib.s_rvalid), 64'h2);
    chk("z_rready", 64'(ib.m_rready), 64'd1);
    tick();
    ib.m_rvalid = 1'b0; ib.m_rlast = 1'b0; ib.s_rready = '0; ib.s_arvalid = 3'b010;
    settle();
    chk("z_g1", 64'(ib.s_arready), 64'h2);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk("z_gn", 64'(ib.s_arready), 64'h2);
      if (k == 0) chk("z_id", 64'(ib.m_arid), 64'h1B);
    end
    tick(); settle();
    chk("z_full", 64'(ib.s_arready), 64'h0);

    // same-cycle grant and rlast on master 0 leaves its count unchanged
    tick(); ib.s_arvalid = 3'b001; settle();
    chk("sim_g1", 64'(ib.s_arready), 64'h1);
    tick(); settle();
    chk("sim_g2", 64'(ib.s_arready), 64'h1);
    tick(); settle();
    chk("sim_g3", 64'(ib.s_arready), 64'h1);
    tick();
    ib.m_rvalid = 1'b1; ib.m_rid = 6'h03; ib.m_rlast = 1'b1; ib.s_rready = 3'b001;
    settle();
    chk("sim_both",   64'(ib.s_arready), 64'h1);
    chk("sim_rvalid", 64'(ib.s_rvalid),  64'h1);
    chk("sim_rready", 64'(ib.m_rready),  64'd1);
    tick();
    ib.m_rvalid = 1'b0; ib.m_rlast = 1'b0; ib.s_rready = '0;
    settle();
    chk("sim_last", 64'(ib.s_arready), 64'h1);
    tick(); settle();
    chk("sim_full", 64'(ib.s_arready), 64'h0);
    chk("sim_err",  64'(err_b),        64'd1);
    chk("a_err",    64'(err_a),        64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
